// File: rtl/shift_pkg.sv
// Shared types and widths for the two-stage shift pipeline.
package shift_pkg;

    localparam int SHIFT_W = 8;
    localparam int SHAMT_W = 3;

    typedef enum logic [1:0] {
        SLL = 2'd0,
        SRL = 2'd1,
        SRA = 2'd2,
        ROL = 2'd3
    } shift_op_t;

endpackage

// File: rtl/mux8.sv
// Single-bit 8:1 selection cell used to build wider datapath selectors.
module mux8 (
    input  logic [7:0] d_i,
    input  logic [2:0] sel_i,
    output logic       y_o
);

    assign y_o = d_i[sel_i];

endmodule

// File: rtl/shifter8.sv
// Purely combinational 8-bit shifter/rotator: one mux8 per result bit, selected by shift amount.
module shifter8
    import shift_pkg::*;
(
    input  logic [SHIFT_W-1:0] data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  shift_op_t          op_i,
    output logic [SHIFT_W-1:0] result_o
);

    for (genvar i = 0; i < SHIFT_W; i++) begin : g_bit
        // cand[s] is what result bit i becomes for a shift amount of s
        logic [SHIFT_W-1:0] cand;

        for (genvar s = 0; s < SHIFT_W; s++) begin : g_amt
            logic sllBit;
            logic srlBit;
            logic sraBit;
            logic rolBit;

            if (i >= s) begin : g_sll_in
                assign sllBit = data_i[i-s];
            end else begin : g_sll_fill
                assign sllBit = 1'b0;
            end

            if (i + s < SHIFT_W) begin : g_sr_in
                assign srlBit = data_i[i+s];
                assign sraBit = data_i[i+s];
            end else begin : g_sr_fill
                assign srlBit = 1'b0;
                assign sraBit = data_i[SHIFT_W-1];
            end

            assign rolBit = data_i[(i - s + SHIFT_W) % SHIFT_W];

            assign cand[s] = (op_i == SLL) ? sllBit :
                             (op_i == SRL) ? srlBit :
                             (op_i == SRA) ? sraBit : rolBit;
        end

        mux8 u_mux (
            .d_i   (cand),
            .sel_i (shamt_i),
            .y_o   (result_o[i])
        );
    end

endmodule

// File: rtl/shift_pipe.sv
// Two-stage valid/ready shift pipeline: S1 captures the request, S2 holds the shifted result.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SHIFT_W-1:0] in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SHIFT_W-1:0] out_data,
    output logic [CNT_W-1:0]   ops_done
);

    logic               s1_valid_q, s1_valid_d;
    logic [SHIFT_W-1:0] s1_data_q,  s1_data_d;
    logic [SHAMT_W-1:0] s1_shamt_q, s1_shamt_d;
    shift_op_t          s1_op_q,    s1_op_d;
    logic               s2_valid_q, s2_valid_d;
    logic [SHIFT_W-1:0] s2_data_q,  s2_data_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;

    logic [SHIFT_W-1:0] shift_res;
    logic               s2_free;
    logic               s1_adv;
    logic               in_fire;
    logic               out_fire;

    shifter8 u_shifter (
        .data_i   (s1_data_q),
        .shamt_i  (s1_shamt_q),
        .op_i     (s1_op_q),
        .result_o (shift_res)
    );

    // S2 can take a new result if it is empty or being drained this cycle
    assign out_fire = s2_valid_q && out_ready;
    assign s2_free  = !s2_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_free;
    assign in_ready = !rst && (!s1_valid_q || s2_free);
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_shamt_d = s1_shamt_q;
        s1_op_d    = s1_op_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        cnt_d      = cnt_q;

        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_data_d  = in_data;
            s1_shamt_d = in_shamt;
            s1_op_d    = shift_op_t'(in_op);
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            s2_valid_d = 1'b1;
            s2_data_d  = shift_res;
        end else if (out_fire) begin
            s2_valid_d = 1'b0;
        end

        if (out_fire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_shamt_q <= '0;
            s1_op_q    <= SLL;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_shamt_q <= s1_shamt_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign ops_done  = cnt_q;

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe; a second 4-bit-counter instance shares the stimulus for the wrap check.
module tb_shift_pipe;
    import shift_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic [2:0]  in_shamt = 3'd0;
    logic [1:0]  in_op = 2'd0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [7:0]  out_data;
    logic [15:0] ops_done;
    logic        in_ready4, out_valid4;
    logic [7:0]  out_data4;
    logic [3:0]  ops_done4;

    int          compared = 0;
    int          mismatched = 0;
    int          outCount = 0;
    logic [7:0]  expQ[$];
    logic [7:0]  expByte;
    logic [7:0]  lastExp;

    always #5 clk = ~clk;

    shift_pipe #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ops_done(ops_done)
    );

    shift_pipe #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .ops_done(ops_done4)
    );

    function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] sh, input logic [1:0] op);
        logic [15:0] w;
        logic [7:0]  r;
        case (op)
            2'd0: r = d << sh;
            2'd1: r = d >> sh;
            2'd2: begin w = {{8{d[7]}}, d} >> sh; r = w[7:0]; end
            default: begin w = {d, d} << sh; r = w[15:8]; end
        endcase
        return r;
    endfunction

    // Monitor: consume results first, then record newly accepted requests
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                compared++;
                outCount++;
                if (expQ.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL scoreboard_unexpected: got %h, required no output", out_data);
                end else begin
                    expByte = expQ.pop_front();
                    if (out_data !== expByte) begin
                        mismatched++;
                        $display("[TB] FAIL scoreboard_data: got %h, required %h", out_data, expByte);
                    end
                end
            end
            if (in_valid && in_ready) begin
                expQ.push_back(model(in_data, in_shamt, in_op));
                lastExp = model(in_data, in_shamt, in_op);
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [2:0] sh, input logic [1:0] op);
        int waitCnt = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = sh;
        in_op    = op;
        @(negedge clk);
        while (!in_ready && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!in_ready) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL send_timeout: in_ready=%b, required 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        while (expQ.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain_timeout: %0d pending, required 0", expQ.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst = 1'b1;
        in_valid = 1'b0;
        expQ.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        compared += 4;
        if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %b, required 0", in_ready); end
        if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %b, required 0", out_valid); end
        if (out_data !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_out_data: got %h, required 00", out_data); end
        if (ops_done !== 16'd0) begin mismatched++; $display("[TB] FAIL reset_ops_done: got %0d, required 0", ops_done); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL release_in_ready: got %b, required 1", in_ready); end
    endtask

    task automatic test_basic();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'hB4; in_shamt = 3'd2; in_op = SRA;
        @(posedge clk); #1;
        in_valid = 1'b0;
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_early_valid: got %b, required 0", out_valid); end
        @(posedge clk); #1;
        compared += 2;
        if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_latency: got %b, required 1", out_valid); end
        if (out_data !== 8'hED) begin mismatched++; $display("[TB] FAIL basic_data: got %h, required ed", out_data); end
        drain();
    endtask

    task automatic test_all_ops();
        logic [7:0] table8 [8] = '{8'h02, 8'h40, 8'hC0, 8'h03, 8'h81, 8'h81, 8'h81, 8'h81};
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            in_valid = 1'b1; in_data = 8'h81; in_shamt = (j < 4) ? 3'd1 : 3'd0; in_op = 2'(j % 4);
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(posedge clk); #1;
            compared++;
            if (out_valid !== 1'b1 || out_data !== table8[j]) begin
                mismatched++;
                $display("[TB] FAIL all_ops_%0d: got v=%b d=%h, required v=1 d=%h", j, out_valid, out_data, table8[j]);
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        int startOut;
        do_reset();
        out_ready = 1'b0;
        startOut = outCount;
        send(8'h5A, 3'd3, SLL);
        send(8'hC3, 3'd4, ROL);
        in_valid = 1'b1; in_data = 8'h96; in_shamt = 3'd5; in_op = SRA;
        for (int c = 0; c < 3; c++) begin
            compared += 3;
            if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_in_ready: got %b, required 0", in_ready); end
            if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_out_valid: got %b, required 1", out_valid); end
            if (out_data !== 8'hD0) begin mismatched++; $display("[TB] FAIL bp_hold: got %h, required d0", out_data); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(8'h96, 3'd5, SRA);
        send(8'h0F, 3'd2, SRL);
        in_valid = 1'b0;
        drain();
        compared++;
        if (outCount - startOut != 4) begin mismatched++; $display("[TB] FAIL bp_count: got %0d, required 4", outCount - startOut); end
    endtask

    task automatic test_back_to_back();
        int vcnt = 0;
        int first = -1;
        int last = -1;
        do_reset();
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 10; i++) send(8'(i * 37 + 5), 3'(i % 8), 2'(i % 4));
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        if (first < 0) first = c;
                        last = c;
                        vcnt++;
                    end
                end
            end
        join
        compared += 3;
        if (vcnt != 10) begin mismatched++; $display("[TB] FAIL stream_count: got %0d, required 10", vcnt); end
        if (last - first != 9) begin mismatched++; $display("[TB] FAIL stream_gap: got span %0d, required 9", last - first); end
        if (ops_done !== 16'd10) begin mismatched++; $display("[TB] FAIL stream_ops_done: got %0d, required 10", ops_done); end
        drain();
    endtask

    task automatic test_reset_midflight();
        int stale = 0;
        do_reset();
        out_ready = 1'b1;
        send(8'h3C, 3'd1, SLL);
        in_valid = 1'b0;
        drain();
        compared++;
        if (ops_done !== 16'd1) begin mismatched++; $display("[TB] FAIL mid_pre_count: got %0d, required 1", ops_done); end
        out_ready = 1'b0;
        send(8'hAA, 3'd1, SRL);
        send(8'h55, 3'd2, ROL);
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        expQ.delete();
        #1;
        compared += 4;
        if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_out_valid: got %b, required 0", out_valid); end
        if (ops_done !== 16'd0) begin mismatched++; $display("[TB] FAIL mid_ops_done: got %0d, required 0", ops_done); end
        if (out_data !== 8'h00) begin mismatched++; $display("[TB] FAIL mid_out_data: got %h, required 00", out_data); end
        if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_in_ready: got %b, required 0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        compared++;
        if (stale != 0) begin mismatched++; $display("[TB] FAIL mid_stale: got %0d outputs, required 0", stale); end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) send(8'(i * 11 + 1), 3'(i % 8), 2'(i % 4));
        in_valid = 1'b0;
        drain();
        @(posedge clk); #1;
        compared += 5;
        if (ops_done4 !== 4'd1) begin mismatched++; $display("[TB] FAIL wrap_cnt4: got %0d, required 1", ops_done4); end
        if (ops_done !== 16'd17) begin mismatched++; $display("[TB] FAIL wrap_cnt16: got %0d, required 17", ops_done); end
        if (out_valid4 !== 1'b0) begin mismatched++; $display("[TB] FAIL wrap_valid4: got %b, required 0", out_valid4); end
        if (in_ready4 !== 1'b1) begin mismatched++; $display("[TB] FAIL wrap_ready4: got %b, required 1", in_ready4); end
        if (out_data4 !== lastExp) begin mismatched++; $display("[TB] FAIL wrap_data4: got %h, required %h", out_data4, lastExp); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_ops();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
